// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game controller and its neighbours
// (display and key control decode the same state codes).
//   state_t       : 3-bit game state encoding
//   TIMER_W       : phase timer width
//   *_DEF         : default timing parameters
//   level_inc()   : saturating level increment
package game_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_DYING = 3'd4,
      S_CLEAR = 3'd5,
      S_OVER  = 3'd6
   } state_t;

   localparam int TIMER_W          = 27;
   localparam int TICK_DIV_DEF     = 2_000_000;
   localparam int READY_CYCLES_DEF = 50_000_000;
   localparam int DEATH_CYCLES_DEF = 75_000_000;
   localparam int CLEAR_CYCLES_DEF = 75_000_000;
   localparam int LIVES_INIT_DEF   = 3;
   localparam int LEVEL_MAX        = 15;

   function automatic logic [3:0] level_inc(input logic [3:0] lvl);
      return (lvl == 4'(LEVEL_MAX)) ? lvl : lvl + 4'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_phase_timer.sv
// phase_timer -- loadable down-counter that times the READY/DYING/CLEAR phases.
//   clk, rst   : clock, async active-low reset
//   load       : load load_val this cycle
//   load_val   : phase length in cycles (phase lasts load_val+1 cycles)
//   done       : counter has reached 0
module phase_timer
   import game_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                count_q <= '0;
      else if (load)           count_q <= load_val;
      else if (count_q != '0)  count_q <= count_q - 1'b1;
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl -- top-level game sequencer.
//   clk, rst     : clock, async active-low reset
//   start, pause : one-cycle debounced pulses
//   crash        : ghost overlaps Pac-Man (level)
//   all_eaten    : bean map empty (level)
//   state        : current state code (game_pkg::state_t)
//   move_tick    : movement strobe, only in PLAY
//   pos_reset    : one-cycle pulse, respawn actors
//   bean_reload  : one-cycle pulse, refill beans
//   lives, level : game counters
//   over         : high while in OVER
module game_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV     = TICK_DIV_DEF,
   parameter int READY_CYCLES = READY_CYCLES_DEF,
   parameter int DEATH_CYCLES = DEATH_CYCLES_DEF,
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
   parameter int LIVES_INIT   = LIVES_INIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       crash,
   input  logic       all_eaten,
   output logic [2:0] state,
   output logic       move_tick,
   output logic       pos_reset,
   output logic       bean_reload,
   output logic [1:0] lives,
   output logic [3:0] level,
   output logic       over
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_t               state_q, state_d;
   logic [1:0]           lives_q, lives_d;
   logic [3:0]           level_q, level_d;
   logic [PRE_W-1:0]     pre_q;
   logic                 pos_reset_q, pos_reset_d;
   logic                 bean_reload_q, bean_reload_d;
   logic                 play_run;     // staying in PLAY this cycle
   logic                 enter_ready;
   logic                 tmr_load;
   logic [TIMER_W-1:0]   tmr_val;
   logic                 tmr_done;

   phase_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      level_d       = level_q;
      pos_reset_d   = 1'b0;
      bean_reload_d = 1'b0;
      play_run      = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d       = S_READY;
               lives_d       = 2'(LIVES_INIT);
               level_d       = '0;
               pos_reset_d   = 1'b1;
               bean_reload_d = 1'b1;
            end
         end
         S_READY: if (tmr_done) state_d = S_PLAY;
         S_PLAY: begin
            if (crash)          state_d = S_DYING;
            else if (all_eaten) state_d = S_CLEAR;
            else if (pause)     state_d = S_PAUSE;
            else                play_run = 1'b1;
         end
         S_PAUSE: if (pause) state_d = S_PLAY;
         S_DYING: begin
            if (tmr_done) begin
               if (lives_q <= 2'd1) begin
                  state_d = S_OVER;
                  lives_d = '0;
               end else begin
                  state_d     = S_READY;
                  lives_d     = lives_q - 2'd1;
                  pos_reset_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (tmr_done) begin
               state_d       = S_READY;
               level_d       = level_inc(level_q);
               pos_reset_d   = 1'b1;
               bean_reload_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Timer is loaded on the transition edge into a timed phase, so the
   // phase lasts CYCLES+1 cycles (counts N..0, leaves the cycle after 0).
   always_comb begin
      tmr_load    = (state_d != state_q) &&
                    (state_d inside {S_READY, S_DYING, S_CLEAR});
      enter_ready = (state_d == S_READY) && (state_q != S_READY);
      case (state_d)
         S_READY: tmr_val = TIMER_W'(READY_CYCLES);
         S_DYING: tmr_val = TIMER_W'(DEATH_CYCLES);
         S_CLEAR: tmr_val = TIMER_W'(CLEAR_CYCLES);
         default: tmr_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lives_q       <= '0;
         level_q       <= '0;
         pre_q         <= '0;
         pos_reset_q   <= 1'b0;
         bean_reload_q <= 1'b0;
      end else begin
         lives_q       <= lives_d;
         level_q       <= level_d;
         pos_reset_q   <= pos_reset_d;
         bean_reload_q <= bean_reload_d;
         // Prescaler only advances on cycles that stay in PLAY, so the
         // count is frozen across the cycle that leaves for PAUSE.
         if (enter_ready)   pre_q <= '0;
         else if (play_run) pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      end
   end

   assign move_tick   = play_run && (pre_q == PRE_LAST);
   assign state       = state_q;
   assign pos_reset   = pos_reset_q;
   assign bean_reload = bean_reload_q;
   assign lives       = lives_q;
   assign level       = level_q;
   assign over        = (state_q == S_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

   localparam int TD = 4, RC = 8, DC = 6, CC = 5, LI = 3;
   localparam int IDLE = 0, READY = 1, PLAY = 2, PAUSE = 3, DYING = 4, CLEAR = 5, OVER = 6;

   logic       clk = 1'b0, rst = 1'b0;
   logic       start = 1'b0, pause = 1'b0, crash = 1'b0, all_eaten = 1'b0;
   logic [2:0] state;
   logic       move_tick, pos_reset, bean_reload, over;
   logic [1:0] lives;
   logic [3:0] level;

   always #5 clk = ~clk;

   game_ctrl #(
      .TICK_DIV(TD), .READY_CYCLES(RC), .DEATH_CYCLES(DC),
      .CLEAR_CYCLES(CC), .LIVES_INIT(LI)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .crash(crash),
      .all_eaten(all_eaten), .state(state), .move_tick(move_tick),
      .pos_reset(pos_reset), .bean_reload(bean_reload), .lives(lives),
      .level(level), .over(over)
   );

   int n_cmp = 0, n_err = 0;

   // Reference model: game phases as "cycles left in phase".
   int m_st, m_left, m_lives, m_level, m_pre;
   bit m_pr, m_br;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_st = IDLE; m_left = 0; m_lives = 0; m_level = 0; m_pre = 0;
      m_pr = 0; m_br = 0;
   endtask

   function automatic bit m_tick(bit p, bit c, bit a);
      return (m_st == PLAY) && !c && !a && !p && (m_pre == TD - 1);
   endfunction

   task automatic m_step(input bit s, input bit p, input bit c, input bit a);
      m_pr = 0; m_br = 0;
      case (m_st)
         IDLE, OVER: if (s) begin
            m_st = READY; m_left = RC + 1; m_lives = LI; m_level = 0;
            m_pr = 1; m_br = 1; m_pre = 0;
         end
         READY: begin m_left--; if (m_left == 0) m_st = PLAY; end
         PLAY: begin
            if (c)      begin m_st = DYING; m_left = DC + 1; end
            else if (a) begin m_st = CLEAR; m_left = CC + 1; end
            else if (p) m_st = PAUSE;
            else        m_pre = (m_pre + 1) % TD;
         end
         PAUSE: if (p) m_st = PLAY;
         DYING: begin
            m_left--;
            if (m_left == 0) begin
               m_lives--;
               if (m_lives == 0) m_st = OVER;
               else begin m_st = READY; m_left = RC + 1; m_pr = 1; m_pre = 0; end
            end
         end
         CLEAR: begin
            m_left--;
            if (m_left == 0) begin
               m_level = (m_level < 15) ? m_level + 1 : 15;
               m_st = READY; m_left = RC + 1; m_pr = 1; m_br = 1; m_pre = 0;
            end
         end
         default: m_st = IDLE;
      endcase
   endtask

   task automatic check_outs(input bit p, input bit c, input bit a);
      chk("state", 32'(state), 32'(m_st));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("level", 32'(level), 32'(m_level));
      chk("over", 32'(over), 32'(m_st == OVER));
      chk("pos_reset", 32'(pos_reset), 32'(m_pr));
      chk("bean_reload", 32'(bean_reload), 32'(m_br));
      chk("move_tick", 32'(move_tick), 32'(m_tick(p, c, a)));
   endtask

   // One clock cycle: drive at negedge, check, then advance the model at posedge.
   task automatic cyc(input bit s, input bit p, input bit c, input bit a);
      @(negedge clk);
      start = s; pause = p; crash = c; all_eaten = a;
      #1;
      check_outs(p, c, a);
      @(posedge clk);
      m_step(s, p, c, a);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_rst();
      @(negedge clk);
      start = 0; pause = 0; crash = 0; all_eaten = 0;
      #2 rst = 1'b0;
      #1 m_reset();
      check_outs(0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      m_reset();
      #3;
      check_outs(0, 0, 0);
      @(negedge clk) rst = 1'b1;
      idle(3);

      // start -> READY for RC+1 cycles -> PLAY, ticks every TD cycles
      cyc(1, 0, 0, 0);
      idle(RC + 1);
      #2 chk("play_after_9", 32'(state), PLAY);
      chk("lives_init", 32'(lives), 3);
      idle(9);

      // three deaths -> OVER, then restart
      cyc(0, 0, 1, 0);
      idle(DC + 1);
      #2 chk("lives_after_death", 32'(lives), 2);
      chk("ready_after_death", 32'(state), READY);
      chk("pos_reset_after_death", 32'(pos_reset), 1);
      idle(RC + 1);
      cyc(0, 0, 1, 0); idle(DC + 1); idle(RC + 1);
      cyc(0, 0, 1, 0); idle(DC + 1);
      #2 chk("over_lives", 32'(lives), 0);
      chk("over_flag", 32'(over), 1);
      idle(2);
      cyc(1, 0, 0, 0);
      idle(RC + 1);
      #2 chk("lives_restart", 32'(lives), 3);

      // crash wins over all_eaten
      cyc(0, 0, 1, 1);
      idle(DC + 1);
      #2 chk("crash_prio_level", 32'(level), 0);
      chk("crash_prio_lives", 32'(lives), 2);
      idle(RC + 1);

      // level clear and saturation
      cyc(0, 0, 0, 1);
      idle(CC + 1);
      #2 chk("level_1", 32'(level), 1);
      chk("clear_bean_reload", 32'(bean_reload), 1);
      chk("clear_pos_reset", 32'(pos_reset), 1);
      idle(RC + 1);
      repeat (15) begin cyc(0, 0, 0, 1); idle(CC + 1); idle(RC + 1); end
      #2 chk("level_sat", 32'(level), 15);

      // pause at prescaler count 2, crash/start ignored while paused
      idle(2);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 1); cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      @(negedge clk);
      #1 chk("tick_after_resume", 32'(move_tick), 1);
      @(posedge clk) m_step(0, 0, 0, 0);

      // reset in DYING with the timer at 3
      cyc(0, 0, 1, 0);
      idle(3);
      do_rst();
      chk("rst_state", 32'(state), IDLE);
      chk("rst_lives", 32'(lives), 0);
      idle(12);

      // randomized play against the model
      repeat (2500) begin
         if ($urandom_range(0, 399) == 0) do_rst();
         else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 23) == 0, $urandom_range(0, 29) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 2_000_000: clk cycles per movement tick in PLAY (minimum 2).
REQ-002 Parameter READY_CYCLES, default 50_000_000: READY phase duration in clk cycles (minimum 1).
REQ-003 Parameter DEATH_CYCLES, default 75_000_000: DYING phase duration (minimum 1).
REQ-004 Parameter CLEAR_CYCLES, default 75_000_000: CLEAR phase duration (minimum 1).
REQ-005 Parameter LIVES_INIT, default 3: lives at game start, range 1..3.
REQ-006 clk  input  1  system clock, single clock domain.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle debounced pulse; starts or restarts a game.
REQ-009 pause  input  1  one-cycle debounced pulse; toggles PLAY/PAUSE.
REQ-010 crash  input  1  level; a ghost overlaps Pac-Man.
REQ-011 all_eaten  input  1  level; the bean map is empty.
REQ-012 state  output  3  current state encoding.
REQ-013 move_tick  output  1  one-cycle movement strobe shared by the Pac-Man and ghost movers.
REQ-014 pos_reset  output  1  one-cycle pulse; return Pac-Man and ghosts to spawn.
REQ-015 bean_reload  output  1  one-cycle pulse; refill the bean map.
REQ-016 lives  output  2  remaining lives.
REQ-017 level  output  4  current level, starting at 0.
REQ-018 over  output  1  high exactly while in OVER.

Function
REQ-019 States: IDLE=0, READY=1, PLAY=2, PAUSE=3, DYING=4, CLEAR=5, OVER=6; codes 7 and undefined states shall go to IDLE.
REQ-020 IDLE or OVER, start=1: next state READY; lives<=LIVES_INIT; level<=0; pos_reset and bean_reload pulse in the following cycle.
REQ-021 READY: the phase timer loads READY_CYCLES on entry; the state moves to PLAY in the cycle after the timer reaches 0.
REQ-022 PLAY: priority is crash > all_eaten > pause; crash goes to DYING, all_eaten to CLEAR, pause to PAUSE.
REQ-023 PAUSE: pause=1 returns to PLAY; crash, all_eaten and start are ignored.
REQ-024 start shall be ignored in READY, PLAY, PAUSE, DYING and CLEAR.
REQ-025 DYING: timer loads DEATH_CYCLES; at expiry lives decrements; if lives was 1 the next state is OVER (lives=0), otherwise READY with a pos_reset pulse.
REQ-026 CLEAR: timer loads CLEAR_CYCLES; at expiry the next state is READY, level increments and saturates at 15, and pos_reset and bean_reload pulse.
REQ-027 Tick prescaler counts 0..TICK_DIV-1 only in PLAY; move_tick is high for the one cycle when the count equals TICK_DIV-1.
REQ-028 The prescaler freezes in PAUSE and clears to 0 on entry to READY.
REQ-029 move_tick shall be 0 in every state other than PLAY, including the cycle a crash is taken.
REQ-030 pos_reset and bean_reload are registered and never wider than one cycle.
REQ-031 The phase timer is 27 bits wide; a CYCLES value of 1 yields a phase of exactly 2 clk cycles.

Reset
REQ-032 rst=0 asynchronously forces state=IDLE, lives=0, level=0, both counters 0, and all pulse outputs and over to 0.
REQ-033 A reset mid-phase shall abort that phase with no deferred pulses after release.

Structure
REQ-034 Shared package game_pkg holds the state encoding constants and the default timing parameters; Display and KeyControl reuse the same state codes.
REQ-035 One sub-module, phase_timer, provides load, count-down and done, and is instantiated once.

Verification (TICK_DIV=4, READY=8, DEATH=6, CLEAR=5, LIVES_INIT=3)
REQ-036 start in IDLE -> pos_reset=bean_reload=1 for 1 cycle, lives=3, state=PLAY after 9 cycles, then move_tick every 4th cycle.
REQ-037 crash in PLAY -> DYING with move_tick=0; after 7 cycles lives=2, state=READY and pos_reset pulses; three crashes total -> lives=0, over=1; start then gives lives=3.
REQ-038 crash and all_eaten asserted in the same PLAY cycle -> DYING, and level stays 0.
REQ-039 all_eaten in PLAY -> CLEAR; after 6 cycles level=1 with bean_reload and pos_reset pulses; 16 clears leave level=15.
REQ-040 pause at prescaler count 2 -> move_tick stays 0 and the count holds at 2; a second pause makes move_tick fire 1 cycle after PLAY resumes; crash during PAUSE is ignored.
REQ-041 rst=0 in DYING with timer at 3 -> state=IDLE, lives=0 at once; after release no pulses and no state change until start.
